poly1305_mulred_pipe: RTL and testbench

// Parametrised Poly1305 block engine: computes a_out = ((a_in + padded msg) * r) mod P, P = 2^130-5.

---
 rtl/poly1305_mulred_pipe.sv | 141 ++++++++++++++
 tb/tb_poly1305_mulred_pipe.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/poly1305_mulred_pipe.sv
// Poly1305 block engine: a_out = ((a_in + padded msg) * r) mod 2^130-5, always canonical (< P).
// Limb-serial multiply consumes LIMB_W bits of the reduced sum per cycle, folding via 2^130 == 5.
module poly1305_mulred_pipe #(
  parameter int LIMB_W = 32,
  parameter bit CLAMP  = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] r_i,
  input  logic [127:0] msg_i,
  input  logic [4:0]   msg_bytes_i,
  input  logic [129:0] a_in_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [129:0] a_out_o,
  output logic         busy_o
);
  localparam int ITER = (130 + LIMB_W - 1) / LIMB_W;
  localparam int CW   = $clog2(ITER + 1);
  localparam int PW   = 130 + LIMB_W;
  localparam logic [129:0] P     = {2'b11, 128'hffffffff_ffffffff_ffffffff_fffffffb};
  localparam logic [130:0] P131  = {1'b0, P};
  localparam logic [127:0] CLAMP_MASK = 128'h0ffffffc_0ffffffc_0ffffffc_0fffffff;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_RED  = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  if (!(LIMB_W == 8 || LIMB_W == 16 || LIMB_W == 26 || LIMB_W == 32)) begin : g_bad_limb_w
    $error("poly1305_mulred_pipe: LIMB_W must be 8, 16, 26 or 32");
  end

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [129:0]  rr_q, rr_d;
  logic [129:0]  rm_q, rm_d;
  logic [131:0]  acc_q, acc_d;
  logic [129:0]  a_out_q, a_out_d;

  // Accept path: mask unused bytes, place pad bit, add accumulator, pre-fold bit 130.
  logic [4:0]   nb;
  logic [127:0] msg_m;
  logic [128:0] m_pad;
  logic [130:0] sum;
  logic [129:0] rm_init;
  logic [129:0] rr_init;

  assign nb = (msg_bytes_i > 5'd16) ? 5'd16 : msg_bytes_i;

  for (genvar gi = 0; gi < 16; gi++) begin : g_mask
    assign msg_m[8*gi +: 8] = (nb > 5'(gi)) ? msg_i[8*gi +: 8] : 8'h00;
  end

  assign m_pad   = {1'b0, msg_m} | (129'd1 << {nb, 3'b000});
  assign sum     = {2'b00, m_pad} + {1'b0, a_in_i};
  assign rm_init = sum[130] ? (sum[129:0] + 130'd5) : sum[129:0];
  assign rr_init = CLAMP ? {2'b00, r_i & CLAMP_MASK} : {2'b00, r_i};

  // One multiply step: the product's bits above 2^130 fold back times 5, as do acc's top bits.
  logic [PW-1:0] prod;
  logic [PW-1:0] rr_sh;
  logic [131:0]  acc_sum;
  logic [130:0]  rr_t;
  logic [129:0]  rr_nx;

  assign prod    = {{LIMB_W{1'b0}}, rr_q} * {{130{1'b0}}, rm_q[LIMB_W-1:0]};
  assign acc_sum = 132'(acc_q[129:0]) + 132'(acc_q[131:130]) * 132'd5
                 + 132'(prod[129:0]) + 132'(prod[PW-1:130]) * 132'd5;
  assign rr_sh   = {{LIMB_W{1'b0}}, rr_q} << LIMB_W;
  assign rr_t    = 131'(rr_sh[129:0]) + 131'(rr_sh[PW-1:130]) * 131'd5;
  // A second carry out of rr_t only happens when the low part is tiny, so one more +5 cannot overflow.
  assign rr_nx   = rr_t[129:0] + (rr_t[130] ? 130'd5 : 130'd0);

  // Final fold leaves at most 2^130+14, so a single conditional subtract makes it canonical.
  logic [130:0] fold;
  logic         fold_ge;
  assign fold    = 131'(acc_q[129:0]) + 131'(acc_q[131:130]) * 131'd5;
  assign fold_ge = (fold >= P131);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    rm_d    = rm_q;
    acc_d   = acc_q;
    a_out_d = a_out_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          state_d = S_MUL;
          rr_d    = rr_init;
          rm_d    = rm_init;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      S_MUL: begin
        acc_d = acc_sum;
        rr_d  = rr_nx;
        rm_d  = rm_q >> LIMB_W;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ITER - 1)) state_d = S_RED;
      end
      S_RED: begin
        a_out_d = fold_ge ? 130'(fold - P131) : fold[129:0];
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rr_q    <= '0;
      rm_q    <= '0;
      acc_q   <= '0;
      a_out_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      rm_q    <= rm_d;
      acc_q   <= acc_d;
      a_out_q <= a_out_d;
    end
  end

  assign in_ready_o  = (state_q == S_IDLE);
  assign out_valid_o = (state_q == S_HOLD);
  assign busy_o      = (state_q != S_IDLE);
  assign a_out_o     = a_out_q;

endmodule

// File: tb/tb_poly1305_mulred_pipe.sv
// Bench for poly1305_mulred_pipe: directed vectors on a LIMB_W=32 instance plus random blocks
// on every LIMB_W/CLAMP combination, all checked against a bignum (a+m')*r mod P model.
module tb_poly1305_mulred_pipe;
  localparam logic [129:0] P      = {2'b11, 128'hffffffff_ffffffff_ffffffff_fffffffb};
  localparam logic [259:0] P_W    = {130'd0, P};
  localparam logic [127:0] CMASK  = 128'h0ffffffc_0ffffffc_0ffffffc_0fffffff;
  localparam int           D_ITER = 5;
  localparam int           N_RAND = 500;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic logic [129:0] model(input logic [127:0] r, input logic [127:0] msg,
                                         input logic [4:0] nb_in, input logic [129:0] a,
                                         input bit clamp);
    logic [259:0] m, rr, s;
    int nb;
    nb = (nb_in > 5'd16) ? 16 : int'(nb_in);
    m = '0;
    for (int i = 0; i < nb; i++) m[8*i +: 8] = msg[8*i +: 8];
    m[8*nb] = 1'b1;
    rr = clamp ? {132'd0, r & CMASK} : {132'd0, r};
    s = {130'd0, a} + m;
    s = (s * rr) % P_W;
    return s[129:0];
  endfunction

  task automatic chk(input string name, input logic [129:0] act, input logic [129:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Directed instance
  logic         d_reset, d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_busy;
  logic [127:0] d_r, d_msg;
  logic [4:0]   d_nb;
  logic [129:0] d_a_in, d_a_out;

  poly1305_mulred_pipe #(.LIMB_W(32), .CLAMP(1'b0)) u_dut (
    .clk(clk), .reset(d_reset),
    .in_valid_i(d_in_valid), .in_ready_o(d_in_ready),
    .r_i(d_r), .msg_i(d_msg), .msg_bytes_i(d_nb), .a_in_i(d_a_in),
    .out_valid_o(d_out_valid), .out_ready_i(d_out_ready),
    .a_out_o(d_a_out), .busy_o(d_busy)
  );

  task automatic drive_accept(input logic [127:0] r, input logic [127:0] msg,
                              input logic [4:0] nb, input logic [129:0] a);
    chk("accept in_ready", 130'(d_in_ready), 130'd1);
    d_r = r; d_msg = msg; d_nb = nb; d_a_in = a; d_in_valid = 1'b1;
    @(posedge clk); #1;
    d_in_valid = 1'b0;
    d_r   = {$urandom, $urandom, $urandom, $urandom};
    d_msg = {$urandom, $urandom, $urandom, $urandom};
    d_nb  = 5'($urandom_range(0, 31));
    d_a_in = {2'b01, $urandom, $urandom, $urandom, $urandom};
  endtask

  // Called at cycle 1 (first cycle after acceptance).
  task automatic wait_result(input string name, input logic [129:0] exp, input int hold);
    int n;
    n = 1;
    while (!d_out_valid && n < 64) begin @(posedge clk); #1; n++; end
    chk({name, " out_valid"}, 130'(d_out_valid), 130'd1);
    if (d_out_valid) begin
      chk({name, " latency"}, 130'(n), 130'(D_ITER + 2));
      chk({name, " a_out"}, d_a_out, exp);
      chk({name, " busy"}, 130'(d_busy), 130'd1);
      chk({name, " in_ready"}, 130'(d_in_ready), 130'd0);
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        chk({name, " hold out_valid"}, 130'(d_out_valid), 130'd1);
        chk({name, " hold a_out"}, d_a_out, exp);
        chk({name, " hold in_ready"}, 130'(d_in_ready), 130'd0);
      end
      d_out_ready = 1'b1;
      @(posedge clk); #1;
      d_out_ready = 1'b0;
      chk({name, " post out_valid"}, 130'(d_out_valid), 130'd0);
      chk({name, " post in_ready"}, 130'(d_in_ready), 130'd1);
      chk({name, " post busy"}, 130'(d_busy), 130'd0);
      $display("directed %s: a_out=%h expected=%h", name, d_a_out, exp);
    end
  endtask

  // Random regression instances, one per LIMB_W/CLAMP combination
  logic       rst_g = 1'b1;
  logic [7:0] done_v;

  for (genvar gi = 0; gi < 8; gi++) begin : g_rand
    localparam int LW = (gi / 2 == 0) ? 8 : (gi / 2 == 1) ? 16 : (gi / 2 == 2) ? 26 : 32;
    localparam bit CL = (gi % 2 == 1);

    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] r, msg;
    logic [4:0]   nb;
    logic [129:0] a_in, a_out;
    logic [129:0] exp_q[$];
    logic         done = 1'b0;

    assign done_v[gi] = done;

    poly1305_mulred_pipe #(.LIMB_W(LW), .CLAMP(CL)) u_dut (
      .clk(clk), .reset(rst_g),
      .in_valid_i(in_valid), .in_ready_o(in_ready),
      .r_i(r), .msg_i(msg), .msg_bytes_i(nb), .a_in_i(a_in),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .a_out_o(a_out), .busy_o(busy)
    );

    initial begin : driver
      int t;
      in_valid = 1'b0; r = '0; msg = '0; nb = '0; a_in = '0;
      wait (!rst_g);
      @(posedge clk); #1;
      for (int k = 0; k < N_RAND; k++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        r   = {$urandom, $urandom, $urandom, $urandom};
        if ($urandom_range(0, 7) == 0) r = '1;
        msg = {$urandom, $urandom, $urandom, $urandom};
        nb  = 5'($urandom_range(0, 20));
        a_in = {2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom};
        if (a_in >= P) a_in = a_in - P;
        if ($urandom_range(0, 7) == 0) a_in = P - 130'd1;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 300) begin @(posedge clk); #1; t++; end
        checks++;
        if (!in_ready) begin
          errors++;
          $display("FAIL cfg%0d accept stall: in_ready=%0b required 1", gi, in_ready);
          break;
        end
        exp_q.push_back(model(r, msg, nb, a_in, CL));
        @(posedge clk); #1;
        in_valid = 1'b0;
      end
      t = 0;
      while (exp_q.size() != 0 && t < 2000) begin @(posedge clk); #1; t++; end
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL cfg%0d drain: %0d results outstanding, required 0", gi, exp_q.size());
      end
      done = 1'b1;
    end

    initial begin : compare
      out_ready = 1'b0;
      forever begin
        @(posedge clk); #1;
        if (!rst_g) begin
          if (out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL cfg%0d spurious out_valid: a_out=%h with no block pending", gi, a_out);
            end else if (a_out !== exp_q[0]) begin
              errors++;
              $display("FAIL cfg%0d a_out: got %h expected %h", gi, a_out, exp_q[0]);
            end
          end
          out_ready = ($urandom_range(0, 3) != 0);
          if (out_valid && out_ready && exp_q.size() != 0) begin
            $display("cfg%0d LIMB_W=%0d CLAMP=%0d a_out=%h", gi, LW, CL, exp_q[0]);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin : main
    int t;
    d_reset = 1'b1; d_in_valid = 1'b0; d_out_ready = 1'b0;
    d_r = '0; d_msg = '0; d_nb = '0; d_a_in = '0;
    repeat (3) @(posedge clk); #1;
    chk("reset in_ready", 130'(d_in_ready), 130'd1);
    chk("reset out_valid", 130'(d_out_valid), 130'd0);
    chk("reset busy", 130'(d_busy), 130'd0);
    chk("reset a_out", d_a_out, 130'd0);
    d_reset = 1'b0;
    rst_g   = 1'b0;

    // Hand-computed pins on the model itself
    chk("model sum=P", model(128'd1, 128'd0, 5'd0, P - 130'd1, 1'b0), 130'd0);
    chk("model 2^130+2", model(128'd2, 128'd0, 5'd0, 130'd1 << 129, 1'b0), 130'd7);
    chk("model msg_bytes=3", model(128'd1, {104'hffffffffffffffffffffffffff, 24'h123456}, 5'd3, 130'd0, 1'b0),
        130'h1123456);
    chk("model clamp", model('1, 128'd0, 5'd0, 130'd0, 1'b1), {2'b00, CMASK});
    chk("model full fold", model('1, '1, 5'd16, P - 130'd1, 1'b0),
        {2'b10, 128'h7fffffff_ffffffff_ffffffff_fffffffd});

    drive_accept(128'd1, 128'd0, 5'd0, P - 130'd1);
    wait_result("sum_eq_p", 130'd0, 0);
    drive_accept(128'd2, 128'd0, 5'd0, 130'd1 << 129);
    wait_result("wrap_7", 130'd7, 0);
    drive_accept('1, '1, 5'd16, P - 130'd1);
    wait_result("full_fold", {2'b10, 128'h7fffffff_ffffffff_ffffffff_fffffffd}, 0);
    drive_accept(128'd1, {104'hffffffffffffffffffffffffff, 24'h123456}, 5'd3, 130'd0);
    wait_result("bytes3", 130'h1123456, 0);
    drive_accept(128'd1, '1, 5'd20, 130'd0);
    wait_result("bytes20", {2'b01, 128'hffffffff_ffffffff_ffffffff_ffffffff}, 0);
    drive_accept(128'd1, 128'd0, 5'd16, 130'd0);
    wait_result("pad_only16", 130'd1 << 128, 0);

    // Backpressure: a second block is offered throughout and must wait for the handshake
    drive_accept(128'd2, 128'd0, 5'd0, 130'd1 << 129);
    d_r = 128'd3; d_msg = 128'h10; d_nb = 5'd1; d_a_in = 130'd5; d_in_valid = 1'b1;
    wait_result("backpressure", 130'd7, 10);
    @(posedge clk); #1;
    d_in_valid = 1'b0;
    wait_result("after_release", 130'h33f, 0);

    // Reset in MUL cycle 2 aborts the block
    drive_accept(128'd1, 128'd0, 5'd0, 130'd0);
    @(posedge clk); #1;
    d_reset = 1'b1;
    @(posedge clk); #1;
    d_reset = 1'b0;
    chk("abort in_ready", 130'(d_in_ready), 130'd1);
    chk("abort out_valid", 130'(d_out_valid), 130'd0);
    chk("abort busy", 130'(d_busy), 130'd0);
    chk("abort a_out", d_a_out, 130'd0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("abort no output", 130'(d_out_valid), 130'd0);
    end
    drive_accept(128'd5, 128'd0, 5'd2, 130'd0);
    wait_result("fresh_after_reset", 130'h50000, 0);

    t = 0;
    while (done_v != 8'hff && t < 90000) begin @(posedge clk); t++; end
    chk("random regressions complete", 130'(done_v), 130'hff);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
